// File: rtl/ifetch_unit.sv
// Instruction fetch stage: two tagged word buffers (current, next-sequential) in front of a
// variable-latency instruction memory, with optional sequential prefetch of the following word.
module ifetch_unit #(
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PREFETCH
  } state_t;

  state_t      state;
  logic        cur_v;
  logic        next_v;
  logic [29:0] cur_tag;
  logic [29:0] next_tag;
  logic [31:0] cur_data;
  logic [31:0] next_data;

  logic [29:0] pc_tag;
  logic [29:0] seq_tag;
  logic        hit_cur;
  logic        hit_nxt;
  logic        hit;
  logic        promote;
  logic        need_pf;
  logic        done;
  logic        fetch_wr;
  logic        pf_wr;
  logic        unused_pc_bits;

  assign pc_tag         = pc[31:2];
  assign unused_pc_bits = ^pc[1:0];

  assign hit_cur = cur_v && (cur_tag == pc_tag);
  assign hit_nxt = next_v && (next_tag == pc_tag);
  assign hit     = hit_cur || hit_nxt;
  assign promote = hit_nxt && !hit_cur;

  // After any hit the current buffer holds pc, so the sequential successor is pc+1 (word tag).
  assign seq_tag = pc_tag + 30'd1;
  assign need_pf = PREFETCH_EN && !(next_v && !promote && (next_tag == seq_tag));

  assign done     = mem_req && mem_ready;
  assign fetch_wr = (state == FETCH) && done && (mem_addr[31:2] == pc_tag) && !flush;
  assign pf_wr    = (state == PREFETCH) && done && !flush;

  always_comb begin
    instr = RESET_INSTR;
    if (hit_cur) begin
      instr = cur_data;
    end else if (hit_nxt) begin
      instr = next_data;
    end
  end

  assign instr_valid = hit;
  assign stall       = !hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_v     <= 1'b0;
      next_v    <= 1'b0;
      cur_tag   <= '0;
      next_tag  <= '0;
      cur_data  <= '0;
      next_data <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      if (flush) begin
        cur_v  <= 1'b0;
        next_v <= 1'b0;
      end else begin
        if (fetch_wr) begin
          cur_tag  <= mem_addr[31:2];
          cur_data <= mem_rdata;
          cur_v    <= 1'b1;
        end else if (promote) begin
          cur_tag  <= next_tag;
          cur_data <= next_data;
          cur_v    <= 1'b1;
          next_v   <= 1'b0;
        end
        // Placed after promotion so a completing prefetch overrides the next_v clear.
        if (pf_wr) begin
          next_tag  <= mem_addr[31:2];
          next_data <= mem_rdata;
          next_v    <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!flush) begin
            if (!hit) begin
              mem_req  <= 1'b1;
              mem_addr <= {pc_tag, 2'b00};
              state    <= FETCH;
            end else if (need_pf) begin
              mem_req  <= 1'b1;
              mem_addr <= {seq_tag, 2'b00};
              state    <= PREFETCH;
            end
          end
        end
        FETCH, PREFETCH: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios, then random pc/flush/mem_ready traffic checked by a
// scoreboard against a generation-tagged memory model (flush models a code-memory rewrite).
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          checks;
  int          failures;
  int          gen;
  bit          mon_en;
  bit          got_valid;
  logic [31:0] q[$];
  logic        prev_req;
  logic        prev_ready;
  logic [31:0] prev_addr;

  ifetch_unit #(
    .PREFETCH_EN(1'b1),
    .RESET_INSTR(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .flush      (flush),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed hash of the word address, re-keyed by each flush generation.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int g);
    logic [31:0] x;
    x = {a[31:2], 2'b00} ^ (32'(g) * 32'h5bd1_e995);
    return x * 32'h9e37_79b1 + 32'h0137_4a5d;
  endfunction

  function automatic logic [31:0] next_base(input logic [31:0] b);
    int r;
    r = $urandom_range(0, 99);
    if (r < 65)      return b + 32'd4;
    else if (r < 80) return 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
    else if (r < 88) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
    else if (r < 94) return b;
    else             return b - 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (flush) gen++;
    mem_rdata = mem_word(mem_addr, gen);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop whenever an instruction is presented.
  always @(negedge clk) begin
    logic [31:0] p;
    logic [31:0] e;
    if (mon_en) begin
      got_valid = instr_valid;
      chk("stall_vs_valid", 32'(stall), 32'(!instr_valid));
      if (!instr_valid) chk("idle_instr", instr, 32'h0);
      if (prev_req && !prev_ready) begin
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("addr_hold", mem_addr, prev_addr);
      end
      if (mem_req) chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
      if (instr_valid) begin
        if (q.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          p = q.pop_front();
          e = mem_word(p, gen);
          chk("sb_instr", instr, e);
          $display("txn pc=%h instr=%h expect=%h gen=%0d", p, instr, e, gen);
        end
      end
    end else begin
      got_valid = 1'b0;
    end
    prev_req   = mem_req;
    prev_ready = mem_ready;
    prev_addr  = mem_addr;
  end

  initial begin
    logic [31:0] base;
    int          wait_cnt;
    checks = 0; failures = 0; gen = 0; mon_en = 1'b0;
    reset = 1'b1; pc = 32'h0; flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0;

    // Reset held with memory ready: nothing may be requested.
    tick(); tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    reset = 1'b0;
    tick();
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr", mem_addr, 32'h0);
    chk("t1_notyet", 32'(instr_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, mem_word(32'h0, gen));

    // Slow memory: request held for three wait cycles.
    do_reset();
    pc = 32'h10; mem_ready = 1'b0;
    tick();
    chk("t2_req", 32'(mem_req), 32'd1);
    chk("t2_addr", mem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold", mem_addr, 32'h10);
      chk("t2_stall", 32'(stall), 32'd1);
    end
    mem_ready = 1'b1;
    tick();
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_instr", instr, mem_word(32'h10, gen));

    // Prefetch of 0x14, then sequential step hits the next buffer and chains 0x18.
    tick();
    chk("t3_pf_req", 32'(mem_req), 32'd1);
    chk("t3_pf_addr", mem_addr, 32'h14);
    tick();
    chk("t3_pf_done", 32'(mem_req), 32'd0);
    pc = 32'h14; #1;
    chk("t3_nostall", 32'(stall), 32'd0);
    chk("t3_instr", instr, mem_word(32'h14, gen));
    tick();
    chk("t3_pf2_addr", mem_addr, 32'h18);
    chk("t3_pf2_req", 32'(mem_req), 32'd1);
    chk("t3_promoted", 32'(instr_valid), 32'd1);
    mem_ready = 1'b0;

    // Jump during outstanding prefetch: prefetch completes first, then demand fetch.
    pc = 32'h100; #1;
    chk("t4_stall", 32'(stall), 32'd1);
    tick(); tick();
    chk("t4_hold_addr", mem_addr, 32'h18);
    chk("t4_hold_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1;
    tick();
    chk("t4_pf_end", 32'(mem_req), 32'd0);
    tick();
    chk("t4_fetch_addr", mem_addr, 32'h100);
    tick();
    chk("t4_instr", instr, mem_word(32'h100, gen));

    // Flush in the same cycle as the response: data dropped, refetch.
    do_reset();
    pc = 32'h20; mem_ready = 1'b0;
    tick();
    chk("t5_addr", mem_addr, 32'h20);
    flush = 1'b1; mem_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_dropped", 32'(instr_valid), 32'd0);
    chk("t5_req_off", 32'(mem_req), 32'd0);
    tick();
    chk("t5_refetch", mem_addr, 32'h20);
    chk("t5_refetch_req", 32'(mem_req), 32'd1);
    tick();
    chk("t5_instr", instr, mem_word(32'h20, gen));

    // Top-of-memory wrap of the sequential prefetch address.
    do_reset();
    pc = 32'hFFFF_FFFC; mem_ready = 1'b1;
    tick(); tick();
    chk("t6_instr", instr, mem_word(32'hFFFF_FFFC, gen));
    tick();
    chk("t6_wrap_addr", mem_addr, 32'h0);
    chk("t6_wrap_req", 32'(mem_req), 32'd1);
    tick();
    pc = 32'h0; #1;
    chk("t6_hit_next", 32'(instr_valid), 32'd1);
    chk("t6_next_instr", instr, mem_word(32'h0, gen));
    mem_ready = 1'b0;
    tick();
    chk("t6_pf_req", 32'(mem_req), 32'd1);

    // Reset mid-transaction drops the request without waiting for a clock.
    reset = 1'b1; #1;
    chk("rst_async_drop", 32'(mem_req), 32'd0);
    tick();
    reset = 1'b0;

    // Random traffic under the scoreboard.
    base = 32'h100;
    pc = base;
    q.push_back(pc);
    mon_en = 1'b1;
    wait_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      flush = ($urandom_range(0, 39) == 0);
      mem_ready = ($urandom_range(0, 99) < 60);
      if (got_valid) begin
        base = next_base(base);
        pc = base | 32'($urandom_range(0, 3));
        q.push_back(pc);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt > 150) begin
          failures++;
          $display("FAIL timeout: pc=%h no instruction after %0d cycles", pc, wait_cnt);
          break;
        end
      end
    end
    mon_en = 1'b0;
    flush = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
